// File: rtl/full_adder_bist.sv
// rtl/full_adder_bist.sv - BIST controller applying all eight {a,b,cin} vectors to a 1-bit full adder
// Optional FA_BIST_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module full_adder_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       fa_a,
    output logic       fa_b,
    output logic       fa_cin,
    input  logic       fa_sum,
    input  logic       fa_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err;
    logic       r_fail_valid;
    logic [2:0] r_first_fail;

    logic w_exp_sum;
    logic w_exp_cout;
    logic w_mismatch;
    logic w_last;

    assign w_exp_sum  = r_vec[2] ^ r_vec[1] ^ r_vec[0];
    assign w_exp_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
    assign w_mismatch = (fa_sum != w_exp_sum) || (fa_cout != w_exp_cout);

`ifdef FA_BIST_STOP_ON_FAIL_EN
    assign w_last = (r_vec == 3'd7) || w_mismatch;
`else
    assign w_last = (r_vec == 3'd7);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vec        <= 3'd0;
            r_cnt        <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 4'd0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec        <= 3'd0;
                        r_cnt        <= 4'd0;
                        r_err        <= 4'd0;
                        r_fail_valid <= 1'b0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= r_err + 4'd1;
                        if (!r_fail_valid) begin
                            r_first_fail <= r_vec;
                            r_fail_valid <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + 3'd1;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // r_err already includes the last CHECK, so pass reflects the whole run
                    r_pass  <= (r_err == 4'd0);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign {fa_a, fa_b, fa_cin} = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;

endmodule

// File: tb/tb_full_adder_bist.sv
// tb/tb_full_adder_bist.sv - scoreboard bench for full_adder_bist with S=1 and S=3 instances
module tb_full_adder_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    int   mode1 = 0;
    int   mode3 = 0;
    logic sel = 1'b0;

    logic d1_a, d1_b, d1_cin, d1_sum, d1_cout, d1_busy, d1_done, d1_pass, d1_fv;
    logic [3:0] d1_err;
    logic [2:0] d1_ff;
    logic d3_a, d3_b, d3_cin, d3_sum, d3_cout, d3_busy, d3_done, d3_pass, d3_fv;
    logic [3:0] d3_err;
    logic [2:0] d3_ff;

    always #5 clk = ~clk;

    // adder models: 0 = correct, 1 = cout stuck at 0, 2 = sum inverted
    always_comb begin
        d1_sum  = d1_a ^ d1_b ^ d1_cin ^ (mode1 == 2);
        d1_cout = (mode1 == 1) ? 1'b0 : ((d1_a & d1_b) | (d1_a & d1_cin) | (d1_b & d1_cin));
        d3_sum  = d3_a ^ d3_b ^ d3_cin ^ (mode3 == 2);
        d3_cout = (mode3 == 1) ? 1'b0 : ((d3_a & d3_b) | (d3_a & d3_cin) | (d3_b & d3_cin));
    end

    full_adder_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .fa_a(d1_a), .fa_b(d1_b), .fa_cin(d1_cin),
        .fa_sum(d1_sum), .fa_cout(d1_cout),
        .busy(d1_busy), .done(d1_done), .pass(d1_pass),
        .err_count(d1_err), .fail_valid(d1_fv), .first_fail(d1_ff)
    );

    full_adder_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .fa_a(d3_a), .fa_b(d3_b), .fa_cin(d3_cin),
        .fa_sum(d3_sum), .fa_cout(d3_cout),
        .busy(d3_busy), .done(d3_done), .pass(d3_pass),
        .err_count(d3_err), .fail_valid(d3_fv), .first_fail(d3_ff)
    );

    logic [2:0] o_vec, o_ff;
    logic [3:0] o_err;
    logic       o_busy, o_done, o_pass, o_fv;
    assign o_vec  = sel ? {d3_a, d3_b, d3_cin} : {d1_a, d1_b, d1_cin};
    assign o_ff   = sel ? d3_ff : d1_ff;
    assign o_err  = sel ? d3_err : d1_err;
    assign o_busy = sel ? d3_busy : d1_busy;
    assign o_done = sel ? d3_done : d1_done;
    assign o_pass = sel ? d3_pass : d1_pass;
    assign o_fv   = sel ? d3_fv : d1_fv;

    typedef struct {
        int lat;
        int pass;
        int err;
        int fv;
        int ff;
        int last;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int mode, input int s);
        exp_t e;
        e.err = 0; e.fv = 0; e.ff = 0; e.last = 7; e.lat = 8 * (s + 1);
        for (int v = 0; v < 8; v++) begin
            int a, b, c, gs, gc, ds, dc;
            a = (v >> 2) & 1; b = (v >> 1) & 1; c = v & 1;
            gs = a ^ b ^ c;
            gc = (a & b) | (a & c) | (b & c);
            ds = (mode == 2) ? (gs ^ 1) : gs;
            dc = (mode == 1) ? 0 : gc;
            if (ds != gs || dc != gc) begin
                e.err++;
                if (e.fv == 0) begin
                    e.fv = 1;
                    e.ff = v;
                end
`ifdef FA_BIST_STOP_ON_FAIL_EN
                e.last = v;
                e.lat = (v + 1) * (s + 1);
                break;
`endif
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic run(input bit s3, input int mode, input int restart_at);
        int   s;
        int   n;
        bit   seen;
        exp_t got;
        s = s3 ? 3 : 1;
        sel = s3;
        if (s3) mode3 = mode; else mode1 = mode;
        sbq.push_back(model(mode, s));
        if (s3) start3 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
        chk("busy_rise", o_busy, 1);
        chk("pass_clear", o_pass, 0);
        seen = 0;
        for (n = 0; n < 300; n++) begin
            if (o_done) begin
                seen = 1;
                break;
            end
            if (mode == 0 && !s3) chk("vec_order", o_vec, n / (s + 1));
            if (s3) start3 = (n == restart_at); else start1 = (n == restart_at);
            tick();
            start1 = 1'b0;
            start3 = 1'b0;
        end
        chk("done_seen", seen, 1);
        got = sbq.pop_front();
        chk("latency", n, got.lat);
        chk("err_count", o_err, got.err);
        chk("fail_valid", o_fv, got.fv);
        if (got.fv != 0) chk("first_fail", o_ff, got.ff);
        chk("vec_hold", o_vec, got.last);
        tick();
        chk("done_pulse", o_done, 0);
        chk("busy_fall", o_busy, 0);
        chk("pass", o_pass, got.pass);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_vec", {d1_a, d1_b, d1_cin}, 0);
        chk("rst_busy", d1_busy, 0);
        chk("rst_done", d1_done, 0);
        chk("rst_pass", d1_pass, 0);
        chk("rst_err", d1_err, 0);
        chk("rst_fv", d1_fv, 0);
        chk("rst_ff", d1_ff, 0);

        run(1'b0, 0, -1);
        run(1'b0, 1, -1);
        run(1'b0, 2, -1);
        run(1'b0, 0, -1);
        run(1'b1, 0, 5);

        // reset taken mid-run
        sel = 1'b0;
        mode1 = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_vec", o_vec, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_pass", o_pass, 0);
        chk("mid_rst_err", o_err, 0);
        chk("mid_rst_fv", o_fv, 0);
        chk("mid_rst_ff", o_ff, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_done || o_busy) seen = 1;
            tick();
        end
        chk("mid_rst_quiet", seen, 0);
        run(1'b0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder_bist.md
# full_adder_bist

Synthesizable built-in self-test controller for the 1-bit full adder cells (`full_adder_beh` and siblings). It drives all eight `{a,b,cin}` input combinations into an attached adder and checks the returned `sum`/`cout` against the truth table. It reports pass/fail, an error count and the first failing vector. It sits beside the adder under test and replaces simulation-only stimulus when adder checks run on hardware.

## Interface
- `SETTLE_CYCLES`, default 1: clock cycles a vector is held before its response is sampled; legal range 1..15.
- `clk  in  1`: single clock; all logic is on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: begin a test run; sampled only in IDLE.
- `fa_a  out  1`: adder operand a.
- `fa_b  out  1`: adder operand b.
- `fa_cin  out  1`: adder carry-in.
- `fa_sum  in  1`: adder sum response.
- `fa_cout  in  1`: adder carry-out response.
- `busy  out  1`: high while a run is in progress.
- `done  out  1`: one-cycle pulse when a run ends.
- `pass  out  1`: high when the last completed run had zero mismatches; held until the next start.
- `err_count  out  4`: number of mismatching vectors in the current or last run (0..8).
- `fail_valid  out  1`: high once any mismatch has been recorded in the current or last run.
- `first_fail  out  3`: `{a,b,cin}` of the first mismatching vector; valid when `fail_valid` is high.

## Operation
- Reset values: `fa_a`=`fa_b`=`fa_cin`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail`=0. State is IDLE.
- Reset taken mid-run: the run aborts and all outputs return to their reset values on the next edge. No `done` pulse is produced.
- State register `vec[2:0]` drives `{fa_a,fa_b,fa_cin}` directly and counts 0 to 7 (000, 001, 010, … 111).
- Expected response for `vec`:
  - `exp_sum` = `a^b^cin`
  - `exp_cout` = `(a&b)|(a&cin)|(b&cin)`
- A vector mismatches if `fa_sum`≠`exp_sum` or `fa_cout`≠`exp_cout`. Both bits are compared in the same cycle.
- FSM states:
  - IDLE: `busy`=0. When `start`=1: `vec`←0, settle counter ←0, `err_count`←0, `fail_valid`←0, `pass`←0, next state SETTLE.
  - SETTLE: counter increments each cycle; when counter = `SETTLE_CYCLES`-1, next state CHECK.
  - CHECK: compare inputs against the expected values.
    - On mismatch: `err_count`+1. If `fail_valid`=0, `first_fail`←`vec` and `fail_valid`←1.
    - If `vec`=7: next state DONE.
    - Otherwise: `vec`+1, counter←0, next state SETTLE.
  - DONE (one cycle): `done`=1; `pass`←(final `err_count`==0); next state IDLE.
- `start` outside IDLE is ignored. `start` held high across DONE→IDLE launches a new run from IDLE.
- `err_count` cannot exceed 8; the 4-bit width covers this with no saturation logic.
- `{fa_a,fa_b,fa_cin}` are registered outputs, glitch-free. They stay at the last vector (111) after a run and return to 000 only on start or reset.

## Timing
- Each vector occupies `SETTLE_CYCLES`+1 cycles: S cycles in SETTLE, then 1 in CHECK.
- Let E0 be the edge that samples `start`. Then:
  - `busy` rises after E0.
  - The CHECK of vector 7 occurs in the cycle ending at E0+8·(S+1).
  - `done` is high for the single cycle after that edge.
  - `busy` falls and `pass` becomes valid after edge E0+8·(S+1)+1.
- With S=1: 16 cycles from the `start` edge to `done` high.
- The adder under test must be combinational with settle time below S clock periods.

## Configuration
- `FA_BIST_STOP_ON_FAIL_EN` defined: a CHECK with a mismatch goes directly to DONE, whatever `vec` is. Then `err_count`=1, `first_fail`=failing vector, `pass`=0, and `fa_*` hold the failing vector.
- Not defined: all eight vectors are always applied. `err_count` reports the total number of mismatches.

## Test plan
- Correct behavioural adder attached, S=1, start pulse → `done` pulses 16 cycles after the start edge; `pass`=1, `err_count`=0, `fail_valid`=0; vectors 000..111 observed in order, each held 2 cycles.
- `fa_cout` forced to 0 (macro off) → `err_count`=4, `first_fail`=3'b011, `fail_valid`=1, `pass`=0.
- `fa_sum` inverted (macro off) → `err_count`=8, `first_fail`=3'b000, `pass`=0.
- `FA_BIST_STOP_ON_FAIL_EN` defined, `fa_cout` forced to 0, S=1 → `done` after 8 cycles; `err_count`=1, `first_fail`=3'b011, `{fa_a,fa_b,fa_cin}`=011.
- S=3, start re-pulsed while `busy` → second start ignored; `done` exactly 32 cycles after the first start edge.
- `rst`=1 asserted in cycle 5 of a run → next cycle all outputs at reset values, no `done` pulse; a new start then runs to completion with `pass`=1.
